atm_ledger_arbiter: RTL and testbench

//  Shares one account ledger (balance register + mini-statement history) among N_TERM ATM

---
 rtl/atm_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/atm_ledger_arbiter.sv | 171 +++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM ledger arbiter.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_BAL  = 2'd0,
    OP_WD   = 2'd1,
    OP_DEP  = 2'd2,
    OP_STMT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_INSUFF    = 3'd1,
    ST_NEED_FACE = 3'd2,
    ST_SAT       = 3'd3,
    ST_DAILY     = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_STREAM = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam int DEF_LIMIT    = 10;
  localparam int DEF_INIT_BAL = 100;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin shared ledger for N_TERM ATM terminals with mini-statement history.
// Optional daily withdraw cap enabled by defining ATM_DAILY_CAP_EN.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int N_TERM   = 4,
  parameter int AMT_W    = 4,
  parameter int BAL_W    = 12,
  parameter int INIT_BAL = DEF_INIT_BAL,
  parameter int LIMIT    = DEF_LIMIT,
  parameter int HIST     = 4,
  parameter int DAY_CAP  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_TERM-1:0]       req,
  input  logic [2*N_TERM-1:0]     op,
  input  logic [AMT_W*N_TERM-1:0] amt,
  input  logic [N_TERM-1:0]       face_ok,
  input  logic                    day_clear,
  output logic [N_TERM-1:0]       gnt,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              status,
  output logic [BAL_W-1:0]        balance_out,
  output logic                    stmt_valid,
  output logic [AMT_W:0]          stmt_entry
);

  localparam int IW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int HW = (HIST > 1) ? $clog2(HIST) : 1;
  localparam int CW = $clog2(HIST + 1);

  localparam logic [2:0] IDLE   = 3'(S_IDLE);
  localparam logic [2:0] GRANT  = 3'(S_GRANT);
  localparam logic [2:0] CHECK  = 3'(S_CHECK);
  localparam logic [2:0] UPDATE = 3'(S_UPDATE);
  localparam logic [2:0] STREAM = 3'(S_STREAM);
  localparam logic [2:0] RESP   = 3'(S_RESP);

  localparam logic [BAL_W:0] BAL_MAX = {1'b0, {BAL_W{1'b1}}};
  localparam logic [BAL_W:0] LIMIT_X = (BAL_W + 1)'(LIMIT);

  logic [2:0]        state;
  logic [IW-1:0]     ptr, win, arb_idx;
  logic [N_TERM-1:0] arb_gnt, gnt_r;
  logic              arb_any;
  op_e               op_l;
  logic [AMT_W-1:0]  amt_l;
  status_e           stat_r, stat_c;
  logic [BAL_W-1:0]  balance;
  logic [AMT_W:0]    hist [HIST];
  logic [HW-1:0]     head, rd_idx;
  logic [CW-1:0]     count, stream_k;
  logic [BAL_W:0]    amt_x, bal_x;
  logic              push;

  rr_arbiter #(.N(N_TERM), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign amt_x = {{(BAL_W + 1 - AMT_W){1'b0}}, amt_l};
  assign bal_x = {1'b0, balance};

`ifdef ATM_DAILY_CAP_EN
  localparam logic [BAL_W:0] CAP_X = (BAL_W + 1)'(DAY_CAP);
  logic [BAL_W:0] day_total;

  always_ff @(posedge clk) begin
    if (reset || day_clear) day_total <= '0;
    else if (state == UPDATE && op_l == OP_WD && stat_r == ST_OK)
      day_total <= day_total + amt_x;
  end
`else
  logic unused_day_clear;
  assign unused_day_clear = day_clear ^ (DAY_CAP == 0);
`endif

  // Rejection order: face verification, daily cap, funds; deposits only saturate.
  always_comb begin
    stat_c = ST_OK;
    if (op_l == OP_WD) begin
      if (amt_x > LIMIT_X && !face_ok[win]) stat_c = ST_NEED_FACE;
`ifdef ATM_DAILY_CAP_EN
      else if (day_total + amt_x > CAP_X)   stat_c = ST_DAILY;
`endif
      else if (amt_x > bal_x)               stat_c = ST_INSUFF;
    end else if (op_l == OP_DEP && bal_x + amt_x > BAL_MAX) begin
      stat_c = ST_SAT;
    end
  end

  assign push = (state == UPDATE) && (op_l == OP_WD || op_l == OP_DEP) &&
                (stat_r == ST_OK || stat_r == ST_SAT);

  // head is the next write slot, so the newest entry sits just behind it.
  always_comb begin : rd_sel
    int t;
    t      = (int'(head) + HIST - 1 - int'(stream_k)) % HIST;
    rd_idx = HW'(t);
  end

  always_ff @(posedge clk) begin
    if (push) hist[head] <= {op_l == OP_DEP, amt_l};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      gnt_r    <= '0;
      op_l     <= OP_BAL;
      amt_l    <= '0;
      stat_r   <= ST_OK;
      balance  <= BAL_W'(INIT_BAL);
      head     <= '0;
      count    <= '0;
      stream_k <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          win   <= arb_idx;
          gnt_r <= arb_gnt;
          op_l  <= op_e'(op[2*arb_idx +: 2]);
          amt_l <= amt[AMT_W*arb_idx +: AMT_W];
          state <= GRANT;
        end
        GRANT: state <= CHECK;
        CHECK: begin
          stat_r <= stat_c;
          state  <= UPDATE;
        end
        UPDATE: begin
          if (op_l == OP_WD && stat_r == ST_OK)  balance <= balance - amt_x[BAL_W-1:0];
          if (op_l == OP_DEP && stat_r == ST_OK) balance <= balance + amt_x[BAL_W-1:0];
          if (op_l == OP_DEP && stat_r == ST_SAT) balance <= '1;
          if (push) begin
            head <= (head == HW'(HIST - 1)) ? '0 : head + 1'b1;
            if (count != CW'(HIST)) count <= count + 1'b1;
          end
          stream_k <= '0;
          state    <= (op_l == OP_STMT && count != '0) ? STREAM : RESP;
        end
        STREAM: begin
          stream_k <= stream_k + 1'b1;
          if (stream_k == count - 1'b1) state <= RESP;
        end
        RESP: begin
          gnt_r <= '0;
          ptr   <= (win == IW'(N_TERM - 1)) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_r;
  assign busy        = (state != IDLE);
  assign done        = (state == RESP);
  assign status      = stat_r;
  assign balance_out = done ? balance : '0;
  assign stmt_valid  = (state == STREAM);
  assign stmt_entry  = stmt_valid ? hist[rd_idx] : '0;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Randomized and directed bench for atm_ledger_arbiter against a queue-based ledger model.
module tb_atm_ledger_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [15:0] amt;
  logic [3:0]  face_ok;
  logic        day_clear;
  logic [3:0]  gnt;
  logic        busy, done, stmt_valid;
  logic [2:0]  status;
  logic [11:0] balance_out;
  logic [4:0]  stmt_entry;

  int checks   = 0;
  int failures = 0;

  int         m_bal;
  int         m_ptr;
  int         m_total;
  logic [4:0] m_hist[$];

  atm_ledger_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .amt(amt), .face_ok(face_ok),
    .day_clear(day_clear), .gnt(gnt), .busy(busy), .done(done), .status(status),
    .balance_out(balance_out), .stmt_valid(stmt_valid), .stmt_entry(stmt_entry)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void modelPush(input bit dep, input int a);
    m_hist.push_front({dep, 4'(a)});
    if (m_hist.size() > 4) void'(m_hist.pop_back());
  endfunction

  // Ledger rules applied to one granted op; returns expected status.
  function automatic int modelOp(input int opc, input int a, input bit face);
    int st;
    st = 0;
    if (opc == 1) begin
      if (a > 10 && !face) st = 2;
`ifdef ATM_DAILY_CAP_EN
      else if (m_total + a > 20) st = 4;
`endif
      else if (a > m_bal) st = 1;
      else begin
        m_bal   -= a;
        m_total += a;
        modelPush(1'b0, a);
      end
    end else if (opc == 2) begin
      if (m_bal + a > 4095) begin
        st    = 3;
        m_bal = 4095;
      end else m_bal += a;
      modelPush(1'b1, a);
    end
    return st;
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; req = '0; op = '0; amt = '0; face_ok = '0; day_clear = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_bal", balance_out, 0);
    checkOutput("rst_sv", stmt_valid, 0);
    checkOutput("rst_se", stmt_entry, 0);
    reset = 1'b0;
    m_bal = 100; m_ptr = 0; m_total = 0; m_hist.delete();
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [7:0] ops,
                               input logic [15:0] amts, input logic [3:0] faces);
    logic [3:0] pending;
    logic [4:0] exp_q[$];
    int w, waitc, lat, n, st, opc;
    bit first;
    @(negedge clk);
    req = mask; op = ops; amt = amts; face_ok = faces;
    pending = mask;
    first = 1'b1;
    while (pending != 0) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && pending[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
      end while (gnt == 0 && waitc < 20);
      checkOutput("gnt", gnt, 32'(4'b0001 << w));
      if (first) checkOutput("req_to_gnt", waitc, 1);
      first = 1'b0;
      opc   = int'(ops[2*w +: 2]);
      exp_q = m_hist;
      st    = modelOp(opc, int'(amts[4*w +: 4]), faces[w]);
      lat = 0;
      n   = 0;
      while (!done && lat < 40) begin
        @(negedge clk);
        lat++;
        if (stmt_valid) begin
          checkOutput("stmt_entry", stmt_entry, (n < exp_q.size()) ? 32'(exp_q[n]) : 32'hDEAD);
          n++;
        end
      end
      checkOutput("latency", lat, (opc == 3) ? 3 + exp_q.size() : 3);
      checkOutput("stmt_count", n, (opc == 3) ? exp_q.size() : 0);
      checkOutput("status", status, st);
      checkOutput("balance_out", balance_out, m_bal);
      req[w]     = 1'b0;
      pending[w] = 1'b0;
      m_ptr      = (w + 1) % 4;
    end
  endtask

  task automatic single(input int term, input int opc, input int a, input bit face);
    applyStimulus(4'(1 << term), 8'(opc << (2*term)), 16'(a << (4*term)), 4'(face << term));
  endtask

  initial begin
    reset = 1'b1; req = '0; op = '0; amt = '0; face_ok = '0; day_clear = 1'b0;

    doReset();
    single(0, 1, 5, 1'b0);
    single(1, 1, 12, 1'b0);
    single(1, 1, 12, 1'b1);
    single(2, 1, 0, 1'b0);
    single(3, 2, 0, 1'b0);

    doReset();
    applyStimulus(4'b1111, 8'h00, 16'h0000, 4'h0);

    doReset();
    for (int i = 1; i <= 5; i++) single(0, 2, i, 1'b0);
    single(2, 3, 0, 1'b0);

    doReset();
    single(1, 3, 0, 1'b0);
    for (int i = 0; i < 266; i++) single(i % 4, 2, 15, 1'b0);
    single(2, 2, 15, 1'b0);
    while (m_bal > 3) single(1, 1, (m_bal - 3 > 15) ? 15 : m_bal - 3, 1'b1);
    single(3, 1, 15, 1'b1);
    single(0, 1, 3, 1'b0);

`ifdef ATM_DAILY_CAP_EN
    doReset();
    single(0, 1, 10, 1'b0);
    single(0, 1, 10, 1'b0);
    single(0, 1, 1, 1'b0);
    @(negedge clk); day_clear = 1'b1;
    @(negedge clk); day_clear = 1'b0;
    m_total = 0;
    single(0, 1, 1, 1'b0);
`endif

    // Abort a withdraw while it sits in CHECK.
    doReset();
    @(negedge clk);
    req = 4'b0010; op = 8'b0000_0100; amt = 16'h0050; face_ok = 4'h0;
    @(negedge clk);
    checkOutput("abort_gnt_up", gnt, 4'b0010);
    @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    checkOutput("abort_gnt", gnt, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_busy", busy, 0);
    reset = 1'b0;
    m_bal = 100; m_ptr = 0; m_total = 0; m_hist.delete();
    single(1, 0, 0, 1'b0);

    for (int k = 0; k < 60; k++)
      applyStimulus(4'($urandom_range(1, 15)), 8'($urandom), 16'($urandom), 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
